// File: rtl/conv1d_requant_if.sv
// Bus bundle for conv1d_requant: config cmd/inp0/inp1/ret port plus the
// accumulator-in and result-out valid/ready streams.
`timescale 1ns/1ps
interface conv1d_requant_if;
  logic [6:0]  cmd;
  logic [31:0] inp0;
  logic [31:0] inp1;
  logic [31:0] ret;
  logic        acc_valid;
  logic        acc_ready;
  logic [31:0] acc_data;
  logic [6:0]  acc_channel;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [6:0]  out_channel;

  modport master (
    output cmd, inp0, inp1, acc_valid, acc_data, acc_channel, out_ready,
    input  ret, acc_ready, out_valid, out_data, out_channel
  );

  modport slave (
    input  cmd, inp0, inp1, acc_valid, acc_data, acc_channel, out_ready,
    output ret, acc_ready, out_valid, out_data, out_channel
  );
endinterface

// File: rtl/conv1d_requant.sv
// Requantises int32 conv1d accumulators to int8: bias add, fixed-point multiply,
// rounding shift, output offset, activation clamp, credit-limited output FIFO.
`timescale 1ns/1ps
module conv1d_requant (
  input  logic            clk,
  input  logic            reset,
  conv1d_requant_if.slave bus
);
  localparam int MAX_OUTPUT_CHANNELS = 128;
  localparam int INT32_SIZE          = 32;
  localparam int BYTE_SIZE           = 8;
  localparam int FIFO_DEPTH          = 4;
  localparam int CH_W                = $clog2(MAX_OUTPUT_CHANNELS);
  localparam int PTR_W               = $clog2(FIFO_DEPTH);
  localparam int CNT_W               = $clog2(FIFO_DEPTH + 1);
  localparam logic signed [INT32_SIZE-1:0] INT32_MIN = {1'b1, {(INT32_SIZE-1){1'b0}}};
  localparam logic signed [INT32_SIZE-1:0] INT32_MAX = {1'b0, {(INT32_SIZE-1){1'b1}}};

  logic signed [INT32_SIZE-1:0] bias_tab  [MAX_OUTPUT_CHANNELS];
  logic signed [INT32_SIZE-1:0] mult_tab  [MAX_OUTPUT_CHANNELS];
  logic signed [5:0]            shift_tab [MAX_OUTPUT_CHANNELS];

  logic                         addr_ok;
  logic [CH_W-1:0]              cfg_idx;
  logic signed [INT32_SIZE-1:0] offset_q, act_min_q, act_max_q;
  logic [31:0]                  ret_q, status;
  logic [1:0]                   inflight;
  logic                         idle;
  logic [CNT_W:0]               credit_used;

  // S1 stage
  logic                         accept;
  logic signed [INT32_SIZE-1:0] s1_x_d;
  logic                         s1_valid_q;
  logic signed [INT32_SIZE-1:0] s1_x_q, s1_mult_q, s1_off_q, s1_min_q, s1_max_q;
  logic signed [5:0]            s1_shift_q;
  logic [CH_W-1:0]              s1_ch_q;

  // S2 stage
  logic [5:0]                   neg_shift;
  logic [4:0]                   lsh_d, rsh_d;
  logic signed [INT32_SIZE-1:0] y_d, h_d;
  logic signed [63:0]           prod_d, rnd_d, adj_d;
  logic                         s2_valid_q;
  logic signed [INT32_SIZE-1:0] s2_h_q, s2_off_q, s2_min_q, s2_max_q;
  logic [4:0]                   s2_r_q;
  logic [CH_W-1:0]              s2_ch_q;

  // S3 stage
  logic [INT32_SIZE-1:0]        mask_d, rem_d, thr_d;
  logic signed [INT32_SIZE-1:0] q_d;
  logic signed [INT32_SIZE:0]   z_d, min_x, max_x, clamp_d;
  logic [BYTE_SIZE-1:0]         res_d;

  // Output FIFO
  logic [BYTE_SIZE-1:0]         fifo_data_q [FIFO_DEPTH];
  logic [CH_W-1:0]              fifo_ch_q   [FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]             count_q;
  logic                         push, pop;

  assign addr_ok = (bus.inp0 < 32'(MAX_OUTPUT_CHANNELS));
  assign cfg_idx = bus.inp0[CH_W-1:0];

  // Tables survive reset; nonblocking writes make same-cycle lookups read-first.
  always_ff @(posedge clk) begin
    if (addr_ok) begin
      case (bus.cmd)
        7'd1:    bias_tab[cfg_idx]  <= bus.inp1;
        7'd2:    mult_tab[cfg_idx]  <= bus.inp1;
        7'd3:    shift_tab[cfg_idx] <= bus.inp1[5:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      offset_q  <= '0;
      act_min_q <= -32'sd128;
      act_max_q <= 32'sd127;
    end else begin
      case (bus.cmd)
        7'd4:    offset_q  <= bus.inp1;
        7'd5:    act_min_q <= bus.inp1;
        7'd6:    act_max_q <= bus.inp1;
        default: ;
      endcase
    end
  end

  assign inflight    = {1'b0, s1_valid_q} + {1'b0, s2_valid_q};
  assign idle        = (count_q == '0) && !s1_valid_q && !s2_valid_q;
  assign status      = {16'b0, 8'(count_q), 7'(inflight), idle};
  assign credit_used = (CNT_W+1)'(count_q) + (CNT_W+1)'(inflight);

  always_ff @(posedge clk) begin
    if (reset) ret_q <= '0;
    else       ret_q <= (bus.cmd == 7'd7) ? status : 32'd0;
  end
  assign bus.ret = ret_q;

  // Credits cover every item past acceptance, so the FIFO can never overflow.
  assign bus.acc_ready = credit_used < (CNT_W+1)'(FIFO_DEPTH);
  assign accept        = bus.acc_valid & bus.acc_ready;
  assign s1_x_d        = bus.acc_data + bias_tab[bus.acc_channel];

  always_ff @(posedge clk) begin
    if (reset) s1_valid_q <= 1'b0;
    else       s1_valid_q <= accept;
  end

  // Layer parameters are captured with the item so later writes never affect it.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_x_q     <= s1_x_d;
      s1_mult_q  <= mult_tab[bus.acc_channel];
      s1_shift_q <= shift_tab[bus.acc_channel];
      s1_ch_q    <= bus.acc_channel;
      s1_off_q   <= offset_q;
      s1_min_q   <= act_min_q;
      s1_max_q   <= act_max_q;
    end
  end

  always_comb begin
    neg_shift = 6'(-s1_shift_q);
    lsh_d     = s1_shift_q[5] ? 5'd0 : s1_shift_q[4:0];
    rsh_d     = !s1_shift_q[5] ? 5'd0 : (neg_shift[5] ? 5'd31 : neg_shift[4:0]);
    y_d       = s1_x_q <<< lsh_d;
    prod_d    = $signed({{32{y_d[31]}}, y_d}) * $signed({{32{s1_mult_q[31]}}, s1_mult_q});
    rnd_d     = prod_d + (prod_d[63] ? -64'sd1073741823 : 64'sd1073741824);
    // Bias negatives up before the arithmetic shift so the divide truncates toward zero.
    adj_d     = rnd_d[63] ? rnd_d + 64'sd2147483647 : rnd_d;
    h_d       = INT32_SIZE'(adj_d >>> 31);
    if (y_d == INT32_MIN && s1_mult_q == INT32_MIN) h_d = INT32_MAX;
  end

  always_ff @(posedge clk) begin
    if (reset) s2_valid_q <= 1'b0;
    else       s2_valid_q <= s1_valid_q;
  end

  always_ff @(posedge clk) begin
    if (s1_valid_q) begin
      s2_h_q   <= h_d;
      s2_r_q   <= rsh_d;
      s2_ch_q  <= s1_ch_q;
      s2_off_q <= s1_off_q;
      s2_min_q <= s1_min_q;
      s2_max_q <= s1_max_q;
    end
  end

  always_comb begin
    mask_d  = (32'd1 << s2_r_q) - 32'd1;
    rem_d   = s2_h_q & mask_d;
    thr_d   = (mask_d >> 1) + {31'b0, s2_h_q[31]};
    q_d     = (s2_h_q >>> s2_r_q) + ((rem_d > thr_d) ? 32'sd1 : 32'sd0);
    z_d     = $signed({q_d[31], q_d}) + $signed({s2_off_q[31], s2_off_q});
    min_x   = $signed({s2_min_q[31], s2_min_q});
    max_x   = $signed({s2_max_q[31], s2_max_q});
    // Max is applied last, so an inverted range resolves to act_max.
    clamp_d = z_d;
    if (z_d < min_x)     clamp_d = min_x;
    if (clamp_d > max_x) clamp_d = max_x;
    res_d   = BYTE_SIZE'(clamp_d);
  end

  assign bus.out_valid   = (count_q != '0);
  assign bus.out_data    = fifo_data_q[rd_ptr_q];
  assign bus.out_channel = fifo_ch_q[rd_ptr_q];
  assign pop             = bus.out_valid & bus.out_ready;
  assign push            = s2_valid_q & ((count_q != CNT_W'(FIFO_DEPTH)) | pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= res_d;
      fifo_ch_q[wr_ptr_q]   <= s2_ch_q;
    end
  end
endmodule

// File: tb/tb_conv1d_requant.sv
// Self-checking bench for conv1d_requant: vector table, stall/credit,
// random traffic against a reference model, and mid-flight reset.
`timescale 1ns/1ps
module tb_conv1d_requant;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv1d_requant_if bus();
  conv1d_requant dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct { logic [7:0] data; logic [6:0] ch; } exp_t;
  typedef struct { int acc; int ch; int bias; int mult; int sh; int off; int amin; int amax; int expv; } vec_t;

  localparam int IMIN = int'(32'h80000000);
  localparam int HALF = 32'h40000000;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic [6:0] c);
    exp_t t;
    t.data = d;
    t.ch   = c;
    exp_q.push_back(t);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h want none", bus.out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(e.data));
        chk("out_channel", 32'(bus.out_channel), 32'(e.ch));
      end
    end
  end

  function automatic logic [7:0] model(input int acc, input int bias, input int mult, input int sh,
                                       input int off, input int amin, input int amax);
    int x, y, r;
    longint p, h, mask, rem, thr, q, z;
    x = acc + bias;
    y = (sh > 0) ? (x << sh) : x;
    if (y == IMIN && mult == IMIN) h = 64'sd2147483647;
    else begin
      p = longint'(y) * longint'(mult);
      p = p + ((p >= 0) ? 64'sd1073741824 : (64'sd1 - 64'sd1073741824));
      h = p / 64'sd2147483648;
    end
    r    = (sh < 0) ? -sh : 0;
    mask = (64'sd1 <<< r) - 64'sd1;
    rem  = h & mask;
    thr  = (mask >>> 1) + ((h < 0) ? 64'sd1 : 64'sd0);
    q    = (h >>> r) + ((rem > thr) ? 64'sd1 : 64'sd0);
    z    = q + longint'(off);
    if (z < longint'(amin)) z = longint'(amin);
    if (z > longint'(amax)) z = longint'(amax);
    return 8'(z);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [6:0] c, input logic [31:0] a, input logic [31:0] v);
    bus.cmd  = c;
    bus.inp0 = a;
    bus.inp1 = v;
    tick();
    bus.cmd  = 7'd0;
  endtask

  task automatic set_channel(input int ch, input int bias, input int mult, input int sh);
    cfg(7'd1, 32'(ch), 32'(bias));
    cfg(7'd2, 32'(ch), 32'(mult));
    cfg(7'd3, 32'(ch), 32'(sh));
  endtask

  task automatic set_layer(input int off, input int amin, input int amax);
    cfg(7'd4, 32'd0, 32'(off));
    cfg(7'd5, 32'd0, 32'(amin));
    cfg(7'd6, 32'd0, 32'(amax));
  endtask

  task automatic read_status(output logic [31:0] r);
    bus.cmd = 7'd7;
    tick();
    bus.cmd = 7'd0;
    r = bus.ret;
  endtask

  // Leaves acc_valid high so consecutive calls stream back to back.
  task automatic send(input int d, input int ch, input logic [7:0] e);
    bit ok = 0;
    bus.acc_valid   = 1'b1;
    bus.acc_data    = 32'(d);
    bus.acc_channel = 7'(ch);
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (bus.acc_ready) begin
        push_exp(e, 7'(ch));
        ok = 1;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept want accept on ch %0d", ch);
    end
  endtask

  task automatic wait_out(input string name);
    int lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = k;
        break;
      end
      tick();
    end
    chk(name, 32'(lat), 32'd3);
    tick();
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 80 && exp_q.size() != 0; k++) tick();
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[12];
    logic [31:0] st;
    int          n_acc;
    int          vals[40];
    int          chs[40];
    int          p_bias[4];
    int          p_mult[4];
    int          p_sh[4];

    vecs[0]  = '{1000,  3,  24, HALF,              -1, -128, -128, 127,  127};
    vecs[1]  = '{-201,  3,   0, HALF,               0,    0, -128, 127, -100};
    vecs[2]  = '{-3,    7,   0, 32'h7FFFFFFF,      -1,    0, -128, 127,   -2};
    vecs[3]  = '{IMIN,  9,   0, IMIN,               0,    0, -128, 127,  127};
    vecs[4]  = '{5,    10,   0, HALF,               2,    0, -128, 127,   10};
    vecs[5]  = '{-1000,20,   0, HALF,               0,    0,  -50,  50,  -50};
    vecs[6]  = '{0,     5,   0, HALF,               0,    0,   10, -10,  -10};
    vecs[7]  = '{6,   127,   0, 32'h7FFFFFFF,      -2,    3, -128, 127,    5};
    vecs[8]  = '{32'h7FFFFFFF, 0, 1, HALF,          0,    0, -128, 127, -128};
    vecs[9]  = '{100,  64,   0, int'(32'hC0000000), 0,    7, -128, 127,  -43};
    vecs[10] = '{10,   12,   0, 32'h7FFFFFFF,      -2,    0, -128, 127,    3};
    vecs[11] = '{-10,  11,   0, 32'h7FFFFFFF,      -2,    0, -128, 127,   -3};

    reset = 1'b1;
    bus.cmd = 7'd0; bus.inp0 = '0; bus.inp1 = '0;
    bus.acc_valid = 1'b0; bus.acc_data = '0; bus.acc_channel = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_acc_ready", 32'(bus.acc_ready), 32'd1);
    chk("rst_ret", bus.ret, 32'd0);
    read_status(st);
    chk("rst_status_idle", st, 32'd1);
    cfg(7'd1, 32'd3, 32'd24);
    chk("ret_after_write", bus.ret, 32'd0);

    foreach (vecs[i]) begin
      set_channel(vecs[i].ch, vecs[i].bias, vecs[i].mult, vecs[i].sh);
      set_layer(vecs[i].off, vecs[i].amin, vecs[i].amax);
      send(vecs[i].acc, vecs[i].ch, 8'(vecs[i].expv));
      bus.acc_valid = 1'b0;
      wait_out($sformatf("latency_vec%0d", i));
    end

    // Same-cycle bias write is not seen by the item accepted with it.
    set_channel(50, 0, HALF, 1);
    set_layer(0, -128, 127);
    bus.cmd = 7'd1; bus.inp0 = 32'd50; bus.inp1 = 32'd1000;
    send(10, 50, 8'd10);
    bus.cmd = 7'd0;
    bus.acc_valid = 1'b0;
    wait_out("latency_readfirst");
    send(10, 50, 8'd127);
    bus.acc_valid = 1'b0;
    wait_out("latency_newbias");

    // Out-of-range address must not alias onto channel 50.
    cfg(7'd1, 32'd50, 32'd0);
    cfg(7'd1, 32'd178, 32'd500);
    send(10, 50, 8'd10);
    bus.acc_valid = 1'b0;
    wait_out("latency_addr_ignore");

    // Stall: credits stop acceptance at the FIFO depth.
    for (int c = 40; c < 46; c++) set_channel(c, 0, HALF, 1);
    for (int i = 0; i < 6; i++) vals[i] = int'($urandom_range(0, 200)) - 100;
    bus.out_ready = 1'b0;
    n_acc = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      bus.acc_valid   = 1'b1;
      bus.acc_data    = 32'(vals[n_acc]);
      bus.acc_channel = 7'(40 + n_acc);
      @(negedge clk);
      if (bus.acc_ready) begin
        push_exp(model(vals[n_acc], 0, HALF, 1, 0, -128, 127), 7'(40 + n_acc));
        n_acc++;
      end
      tick();
    end
    chk("stall_accepts", 32'(n_acc), 32'd4);
    read_status(st);
    chk("stall_status", st, 32'h0000_0400);
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && n_acc < 6; cyc++) begin
      bus.acc_data    = 32'(vals[n_acc]);
      bus.acc_channel = 7'(40 + n_acc);
      @(negedge clk);
      if (bus.acc_ready) begin
        push_exp(model(vals[n_acc], 0, HALF, 1, 0, -128, 127), 7'(40 + n_acc));
        n_acc++;
      end
      tick();
    end
    bus.acc_valid = 1'b0;
    chk("resume_accepts", 32'(n_acc), 32'd6);
    drain("stall_drain");

    // Random traffic with random back-pressure.
    p_bias = '{17, -999, 0, 123456};
    p_mult = '{32'h5A3C1234, 32'h7FFFFFFF, int'(32'hB0000000), 32'h12345678};
    p_sh   = '{-3, 2, -5, 0};
    for (int j = 0; j < 4; j++) set_channel(60 + j, p_bias[j], p_mult[j], p_sh[j]);
    set_layer(5, -100, 90);
    for (int i = 0; i < 40; i++) begin
      vals[i] = (i % 2 == 0) ? int'($urandom()) : int'($urandom_range(0, 4000)) - 2000;
      chs[i]  = int'($urandom_range(0, 3));
    end
    n_acc = 0;
    for (int cyc = 0; cyc < 600 && n_acc < 40; cyc++) begin
      bus.acc_valid   = 1'b1;
      bus.acc_data    = 32'(vals[n_acc]);
      bus.acc_channel = 7'(60 + chs[n_acc]);
      bus.out_ready   = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.acc_ready) begin
        push_exp(model(vals[n_acc], p_bias[chs[n_acc]], p_mult[chs[n_acc]], p_sh[chs[n_acc]], 5, -100, 90),
                 7'(60 + chs[n_acc]));
        n_acc++;
      end
      tick();
    end
    bus.acc_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("rand_accepts", 32'(n_acc), 32'd40);
    drain("rand_drain");
    read_status(st);
    chk("rand_idle", st, 32'd1);

    // Reset with two items in flight and two buffered.
    set_layer(50, -5, 5);
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(i, 40, 8'd5);
    reset = 1'b1;
    bus.acc_valid = 1'b0;
    exp_q.delete();
    tick();
    reset = 1'b0;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_acc_ready", 32'(bus.acc_ready), 32'd1);
    bus.out_ready = 1'b1;
    read_status(st);
    chk("midrst_status_idle", st, 32'd1);
    send(100, 40, 8'd100);
    bus.acc_valid = 1'b0;
    wait_out("latency_after_rst_max");
    send(-100, 40, 8'(-100));
    bus.acc_valid = 1'b0;
    wait_out("latency_after_rst_min");
    drain("final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
